// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Pipelined carry-lookahead adder/subtractor. WIDTH must be a multiple of
//   16. One pipeline stage resolves one 16-bit segment. Each segment uses
//   4-bit lookahead per nibble and a second-order group lookahead for the
//   segment carry-out. The carry is registered between stages.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (x, y, cin, sub)
//   x, y                  operands; sub=0: x+y+cin, sub=1: x-y-cin
//   cin                   carry-in (add) / borrow-in (sub)
//   out_valid / out_ready result handshake (s, cout, ovf, zero)
//   s                     result modulo 2^WIDTH
//   cout                  raw carry out of the MSB (sub: 1 = no borrow)
//   ovf                   two's-complement overflow
//   zero                  s == 0
module pipelined_cla_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int S  = WIDTH / 16;
  localparam int SR = (S > 1) ? S - 1 : 1;

  // 16-bit two-level lookahead: returns {carry_out, sum}.
  function automatic logic [16:0] cla16(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic        c);
    logic [15:0] p, g, cb;
    logic [3:0]  pn, gn;
    logic [4:0]  cn;
    p = a ^ b;
    g = a & b;
    for (int i = 0; i < 4; i++) begin
      pn[i] = &p[4*i +: 4];
      gn[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    end
    cn[0] = c;
    cn[1] = gn[0] | (pn[0] & c);
    cn[2] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & c);
    cn[3] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0])
          | (pn[2] & pn[1] & pn[0] & c);
    // Segment carry-out from the second-order group propagate/generate.
    cn[4] = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1])
          | (pn[3] & pn[2] & pn[1] & gn[0]) | ((&pn) & c);
    for (int i = 0; i < 4; i++) begin
      cb[4*i]   = cn[i];
      cb[4*i+1] = g[4*i] | (p[4*i] & cn[i]);
      cb[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & cn[i]);
      cb[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                | (p[4*i+2] & p[4*i+1] & g[4*i])
                | (p[4*i+2] & p[4*i+1] & p[4*i] & cn[i]);
    end
    return {cn[4], p ^ cb};
  endfunction

  logic [S-1:0]     vld_p;
  logic [S:0]       rdy;
  logic [S-1:0]     up_vld;
  logic [S-1:0]     load;

  // acc_* holds the partially built word: segments below the current stage
  // are already sums, segments at and above it are still x.
  logic [WIDTH-1:0] acc_in [S];
  logic [WIDTH-1:0] acc_nx [S];
  // y_in is kept shifted so the segment being added is always bits [15:0].
  logic [WIDTH-1:0] y_in   [S];
  logic [S-1:0]     c_in;
  logic [S-1:0]     c_nx;
  logic             c_msb;

  logic [WIDTH-1:0] acc_p  [SR];
  logic [WIDTH-1:0] y_p    [SR];
  logic [SR-1:0]    c_p;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  // Handshake: a stage can take new data when empty or when it drains.
  always_comb begin
    rdy[S] = out_ready;
    for (int k = S - 1; k >= 0; k--) begin
      rdy[k] = !vld_p[k] || rdy[k+1];
    end
    up_vld[0] = in_valid;
    for (int k = 1; k < S; k++) begin
      up_vld[k] = vld_p[k-1];
    end
    load = up_vld & rdy[S-1:0];
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_p[S-1];

  always_comb begin
    acc_in[0] = x;
    y_in[0]   = sub ? ~y : y;
    c_in[0]   = cin ^ sub;
    for (int k = 1; k < S; k++) begin
      acc_in[k] = acc_p[k-1];
      y_in[k]   = y_p[k-1];
      c_in[k]   = c_p[k-1];
    end
    for (int k = 0; k < S; k++) begin
      acc_nx[k] = acc_in[k];
      {c_nx[k], acc_nx[k][16*k +: 16]} = cla16(acc_in[k][16*k +: 16], y_in[k][15:0], c_in[k]);
    end
    // Carry into the MSB recovered from the MSB sum and operand bits.
    c_msb = acc_nx[S-1][WIDTH-1] ^ acc_in[S-1][WIDTH-1] ^ y_in[S-1][15];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (rdy[k]) vld_p[k] <= up_vld[k];
      end
    end
  end

  // ---- stage k -> stage k+1 boundary (intermediate stages) ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < S - 1; k++) begin
      if (load[k]) begin
        acc_p[k] <= acc_nx[k];
        y_p[k]   <= y_in[k] >> 16;
        c_p[k]   <= c_nx[k];
      end
    end
  end

  // ---- final stage -> output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (load[S-1]) begin
      s_q    <= acc_nx[S-1];
      cout_q <= c_nx[S-1];
      ovf_q  <= c_nx[S-1] ^ c_msb;
      zero_q <= (acc_nx[S-1] == '0);
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

  logic        clk;
  logic        rst_n;
  logic        iv16, iv32, iv64;
  logic        out_ready;
  logic [63:0] xa, ya;
  logic        ci, sb;

  logic        rdy16, ov16, c16, o16, z16;
  logic [15:0] s16;
  logic        rdy32, ov32, c32, o32, z32;
  logic [31:0] s32;
  logic        rdy64, ov64, c64, o64, z64;
  logic [63:0] s64;

  int n_cmp = 0;
  int n_err = 0;

  logic [33:0] qexp [8];
  logic [31:0] qx [8];
  logic [31:0] qy [8];
  logic        qc [8];
  logic        qs [8];

  pipelined_cla_addsub #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16),
    .x(xa[15:0]), .y(ya[15:0]), .cin(ci), .sub(sb),
    .out_valid(ov16), .out_ready(out_ready), .s(s16),
    .cout(c16), .ovf(o16), .zero(z16));

  pipelined_cla_addsub #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32),
    .x(xa[31:0]), .y(ya[31:0]), .cin(ci), .sub(sb),
    .out_valid(ov32), .out_ready(out_ready), .s(s32),
    .cout(c32), .ovf(o32), .zero(z32));

  pipelined_cla_addsub #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(rdy64),
    .x(xa), .y(ya), .cin(ci), .sub(sb),
    .out_valid(ov64), .out_ready(out_ready), .s(s64),
    .cout(c64), .ovf(o64), .zero(z64));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {cout, ovf, s} for a 32-bit operation.
  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic sbv);
    logic [32:0] w;
    longint      r;
    logic        co, ov;
    if (!sbv) begin
      w  = {1'b0, a} + {1'b0, b} + 33'(c);
      co = w[32];
      r  = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    end else begin
      w  = {1'b0, a} - {1'b0, b} - 33'(c);
      co = ({1'b0, a} >= ({1'b0, b} + 33'(c)));
      r  = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {co, ov, w[31:0]};
  endfunction

  task automatic sample(input int w, output logic [63:0] gs, output logic gc, output logic go,
                        output logic gz, output logic gv, output logic gr);
    case (w)
      16: begin gs = {48'b0, s16}; gc = c16; go = o16; gz = z16; gv = ov16; gr = rdy16; end
      32: begin gs = {32'b0, s32}; gc = c32; go = o32; gz = z32; gv = ov32; gr = rdy32; end
      default: begin gs = s64; gc = c64; go = o64; gz = z64; gv = ov64; gr = rdy64; end
    endcase
  endtask

  // Single directed operation on the instance of width w; elat is the number
  // of extra clock edges after the accepting edge before out_valid shows.
  task automatic op(input int w, input logic [63:0] xv, input logic [63:0] yv,
                    input logic cv, input logic sv, input logic [63:0] es,
                    input logic ec, input logic eo, input logic ez,
                    input int elat, input string tag);
    int n;
    logic [63:0] gs;
    logic gc, go, gz, gv, gr;
    @(negedge clk);
    xa = xv; ya = yv; ci = cv; sb = sv; out_ready = 1'b1;
    case (w)
      16: iv16 = 1'b1;
      32: iv32 = 1'b1;
      default: iv64 = 1'b1;
    endcase
    #1;
    sample(w, gs, gc, go, gz, gv, gr);
    check_eq({tag, "_in_ready"}, 64'(gr), 64'd1);
    @(posedge clk);
    #1;
    iv16 = 1'b0; iv32 = 1'b0; iv64 = 1'b0;
    n = 0;
    sample(w, gs, gc, go, gz, gv, gr);
    while (!gv && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      sample(w, gs, gc, go, gz, gv, gr);
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(elat));
    check_eq({tag, "_s"}, gs, es);
    check_eq({tag, "_flags"}, {61'b0, gc, go, gz}, {61'b0, ec, eo, ez});
  endtask

  // Called at a negedge; samples each cycle 2 time units later and checks
  // results against qexp in order.
  task automatic collect(input int n, input string tag, output int first, output int last);
    int got;
    int cyc;
    got = 0; cyc = 0; first = -1; last = -1;
    while (got < n && cyc < 40) begin
      #2;
      if (ov32 && out_ready) begin
        check_eq(tag, {30'b0, c32, o32, s32}, {30'b0, qexp[got]});
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    int first, last, idx, g;
    logic a;
    clk = 1'b0; rst_n = 1'b0;
    iv16 = 1'b0; iv32 = 1'b0; iv64 = 1'b0;
    out_ready = 1'b1; xa = '0; ya = '0; ci = 1'b0; sb = 1'b0;

    // Reset with random, valid-qualified inputs
    repeat (3) begin
      @(negedge clk);
      xa = {$urandom, $urandom}; ya = {$urandom, $urandom};
      ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      iv32 = 1'b1; iv64 = 1'b1;
    end
    #1;
    check_eq("rst_out_valid", 64'(ov32), 64'd0);
    check_eq("rst_s", 64'(s32), 64'd0);
    check_eq("rst_flags", {61'b0, c32, o32, z32}, 64'd0);
    check_eq("rst_in_ready", 64'(rdy32), 64'd1);
    check_eq("rst_out_valid64", 64'(ov64), 64'd0);
    @(negedge clk);
    iv32 = 1'b0; iv64 = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst2_out_valid", 64'(ov32), 64'd0);
    check_eq("rst2_in_ready", 64'(rdy32), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, WIDTH=32
    op(32, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1, "add_wrap32");
    op(32, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1, "sub_neg32");
    op(32, 64'h8000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1, "sub_ovf32");
    op(32, 64'h7FFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, 64'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1, "add_cin32");
    op(32, 64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0, 1'b0, 1, "sub_borrow32");
    op(32, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1'b0, 1, "add_ovf32");

    // Streaming: 8 back-to-back ops
    for (int i = 0; i < 8; i++) begin
      qx[i] = $urandom; qy[i] = $urandom;
      qc[i] = 1'($urandom_range(0, 1)); qs[i] = 1'(i % 2);
      qexp[i] = model32(qx[i], qy[i], qc[i], qs[i]);
    end
    repeat (2) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          xa = {32'b0, qx[i]}; ya = {32'b0, qy[i]}; ci = qc[i]; sb = qs[i]; iv32 = 1'b1;
          @(negedge clk);
        end
        iv32 = 1'b0;
      end
      collect(8, "stream", first, last);
    join
    check_eq("stream_consecutive", 64'(last - first), 64'd7);

    // Backpressure: out_ready low, offer 4 ops
    for (int i = 0; i < 4; i++) begin
      qx[i] = $urandom; qy[i] = $urandom;
      qc[i] = 1'($urandom_range(0, 1)); qs[i] = 1'(i >= 2);
      qexp[i] = model32(qx[i], qy[i], qc[i], qs[i]);
    end
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      xa = {32'b0, qx[idx]}; ya = {32'b0, qy[idx]}; ci = qc[idx]; sb = qs[idx]; iv32 = 1'b1;
      #1 a = rdy32;
      @(posedge clk);
      if (a) idx++;
      @(negedge clk);
    end
    check_eq("bp_accepted", 64'(idx), 64'd2);
    #1;
    check_eq("bp_in_ready", 64'(rdy32), 64'd0);
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_hold", {29'b0, ov32, c32, o32, s32}, {29'b0, 1'b1, qexp[0]});
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    fork
      begin
        g = 0;
        while (idx < 4 && g < 20) begin
          xa = {32'b0, qx[idx]}; ya = {32'b0, qy[idx]}; ci = qc[idx]; sb = qs[idx]; iv32 = 1'b1;
          #1 a = rdy32;
          @(posedge clk);
          if (a) idx++;
          g++;
          @(negedge clk);
        end
        iv32 = 1'b0;
      end
      collect(4, "bp_drain", first, last);
    join
    repeat (4) begin
      #2 check_eq("bp_no_dup", 64'(ov32), 64'd0);
      @(negedge clk);
    end

    // Reset with two ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      xa = 64'(i + 100); ya = 64'd1; ci = 1'b0; sb = 1'b0; iv32 = 1'b1;
      @(negedge clk);
    end
    iv32 = 1'b0;
    #1 check_eq("mf_full", 64'(ov32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mf_out_valid", 64'(ov32), 64'd0);
    check_eq("mf_s", 64'(s32), 64'd0);
    check_eq("mf_in_ready", 64'(rdy32), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      #2 check_eq("mf_stale", 64'(ov32), 64'd0);
      @(negedge clk);
    end
    op(32, 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0, 1, "post_rst32");

    // WIDTH=16 and WIDTH=64 instances
    op(16, 64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 0, "add_wrap16");
    op(16, 64'h8000, 64'h1, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, 1'b0, 0, "sub_ovf16");
    op(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 3, "add_wrap64");
    op(64, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
       1'b1, 1'b1, 1'b0, 3, "sub_ovf64");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
